compose_power: RTL and testbench

- Inverse of the power decomposition used in hypercube dimension routing: it takes an (n, m) pair and rebuilds the 5-bit value num = 2^n + m.
- Inputs are accepted on a valid/ready stream. Results are delivered on a registered valid/ready stream.
- Illegal pairs are flagged with an error bit.
- Sits at the node-ID reconstruction point, downstream of the routing decomposition.

---
 rtl/compose_power_if.sv | 23 ++
 rtl/compose_power.sv | 124 ++++++++++++
 tb/tb_compose_power.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/compose_power_if.sv
// Stream bundle for compose_power: (n, m) pair in on valid/ready, num/err out on valid/ready.
interface compose_power_if #(
   parameter int NUM_W = 5
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [2:0]       n_i;
   logic [2:0]       m_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [NUM_W-1:0] num_o;
   logic             err_o;

   modport slave (
      input  in_valid_i, n_i, m_i, out_ready_i,
      output in_ready_o, out_valid_o, num_o, err_o
   );

   modport master (
      output in_valid_i, n_i, m_i, out_ready_i,
      input  in_ready_o, out_valid_o, num_o, err_o
   );
endinterface

// File: rtl/compose_power.sv
// Rebuilds num = 2^n + m from an (n, m) pair behind a one-entry registered output stage.
// Optional statistics counters are enabled with the COMPOSE_POWER_STATS_EN macro.
module compose_power #(
   parameter int NUM_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   compose_power_if.slave   bus,
   input  logic             err_clr_i,
   output logic             err_sticky_o,
   output logic [CNT_W-1:0] stat_ok_o,
   output logic [CNT_W-1:0] stat_err_o
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [NUM_W-1:0] num_q, num_d;
   logic             err_q, err_d;
   logic             sticky_q, sticky_d;
   logic             out_valid, in_ready, accept;
   logic [NUM_W:0]   comp;

   // Returns {illegal, num}; illegal pairs produce num = 0.
   function automatic logic [NUM_W:0] compose(input logic [2:0] n, input logic [2:0] m);
      logic             ok;
      logic [NUM_W-1:0] pow;
      pow = NUM_W'(1) << n;
      case (n)
         3'd0:    ok = (m == 3'd0);
         3'd1:    ok = (m <= 3'd1);
         3'd2:    ok = (m <= 3'd3);
         3'd3:    ok = 1'b1;
         3'd4:    ok = (m == 3'd0);
         default: ok = 1'b0;
      endcase
      compose = ok ? {1'b0, pow + NUM_W'(m)} : {1'b1, {NUM_W{1'b0}}};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (&v) ? v : v + CNT_W'(1);
   endfunction

   assign comp   = compose(bus.n_i, bus.m_i);
   assign accept = bus.in_valid_i && in_ready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= EMPTY;
         num_q    <= '0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         num_q    <= num_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (bus.out_ready_i && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Ready depends only on the output side, never on in_valid_i.
   always_comb begin
      out_valid = (state_q == FULL);
      in_ready  = !out_valid || bus.out_ready_i;
   end

   always_comb begin
      num_d    = num_q;
      err_d    = err_q;
      sticky_d = sticky_q;
      if (accept) begin
         num_d = comp[NUM_W-1:0];
         err_d = comp[NUM_W];
      end
      if (accept && comp[NUM_W]) sticky_d = 1'b1;
      else if (err_clr_i)        sticky_d = 1'b0;
   end

   assign bus.out_valid_o = out_valid;
   assign bus.in_ready_o  = in_ready;
   assign bus.num_o       = num_q;
   assign bus.err_o       = err_q;
   assign err_sticky_o    = sticky_q;

`ifdef COMPOSE_POWER_STATS_EN
   logic [CNT_W-1:0] stat_ok_q, stat_ok_d;
   logic [CNT_W-1:0] stat_err_q, stat_err_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_ok_q  <= '0;
         stat_err_q <= '0;
      end else begin
         stat_ok_q  <= stat_ok_d;
         stat_err_q <= stat_err_d;
      end
   end

   // A clear and an accept in the same cycle leave a count of one.
   always_comb begin
      stat_ok_d  = err_clr_i ? '0 : stat_ok_q;
      stat_err_d = err_clr_i ? '0 : stat_err_q;
      if (accept && !comp[NUM_W]) stat_ok_d  = sat_inc(stat_ok_d);
      if (accept && comp[NUM_W])  stat_err_d = sat_inc(stat_err_d);
   end

   assign stat_ok_o  = stat_ok_q;
   assign stat_err_o = stat_err_q;
`else
   assign stat_ok_o  = '0;
   assign stat_err_o = '0;
`endif

endmodule

// File: tb/tb_compose_power.sv
// Self-checking bench for compose_power: directed scenarios then randomized traffic against a queue model.
module tb_compose_power;

`ifdef COMPOSE_POWER_STATS_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 8;
`endif
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             err_clr = 1'b0;
   logic             err_sticky;
   logic [CNT_W-1:0] stat_ok, stat_err;

   int nchk = 0;
   int nerr = 0;

   int exp_q[$];
   bit m_sticky = 1'b0;
   int m_ok = 0;
   int m_er = 0;

   compose_power_if #(.NUM_W(5)) bus ();

   compose_power #(.NUM_W(5), .CNT_W(CNT_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .bus          (bus),
      .err_clr_i    (err_clr),
      .err_sticky_o (err_sticky),
      .stat_ok_o    (stat_ok),
      .stat_err_o   (stat_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: num = 2^n + m, legal only when m lies below 2^n and the result fits in 0..16.
   function automatic int ref_num(input int n, input int m, output bit legal);
      legal = (n <= 4) && (m < (1 << n)) && (((1 << n) + m) <= 16);
      return legal ? (1 << n) + m : 0;
   endfunction

   function automatic int sat(input int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   task automatic check_stats();
`ifdef COMPOSE_POWER_STATS_EN
      check("stat_ok", stat_ok, m_ok);
      check("stat_err", stat_err, m_er);
`else
      check("stat_ok_tied", stat_ok, 0);
      check("stat_err_tied", stat_err, 0);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid_i = 1'b0;
      err_clr = 1'b0;
      exp_q.delete();
      m_sticky = 1'b0;
      m_ok = 0;
      m_er = 0;
      @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid_o, 0);
      check("rst_in_ready", bus.in_ready_o, 1);
      check("rst_num", bus.num_o, 0);
      check("rst_err", bus.err_o, 0);
      check("rst_sticky", err_sticky, 0);
      check_stats();
   endtask

   task automatic cycle(input bit v, input int n, input int m, input bit ordy, input bit clr);
      bit legal;
      bit acc;
      int r;
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid_i  = v;
      bus.n_i         = 3'(n);
      bus.m_i         = 3'(m);
      bus.out_ready_i = ordy;
      err_clr         = clr;
      #1;
      check("out_valid", bus.out_valid_o, exp_q.size() != 0);
      check("in_ready", bus.in_ready_o, (exp_q.size() == 0) || ordy);
      if (exp_q.size() != 0) begin
         check("num", bus.num_o, exp_q[0] & 31);
         check("err", bus.err_o, exp_q[0] >> 8);
      end
      check("sticky", err_sticky, m_sticky);
      check_stats();
      acc = v && ((exp_q.size() == 0) || ordy);
      if ((exp_q.size() != 0) && ordy) void'(exp_q.pop_front());
      r = ref_num(n, m, legal);
      if (acc) exp_q.push_back(r | (legal ? 0 : 256));
      if (acc && !legal) m_sticky = 1'b1;
      else if (clr)      m_sticky = 1'b0;
      if (clr) begin
         m_ok = 0;
         m_er = 0;
      end
      if (acc && legal)  m_ok = sat(m_ok);
      if (acc && !legal) m_er = sat(m_er);
      @(posedge clk);
   endtask

   initial begin
      bus.in_valid_i  = 1'b0;
      bus.n_i         = 3'd0;
      bus.m_i         = 3'd0;
      bus.out_ready_i = 1'b1;

      do_reset();

      // Streaming legal pairs at full throughput: 13, 1, 16.
      cycle(1, 3, 5, 1, 0);
      cycle(1, 0, 0, 1, 0);
      cycle(1, 4, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);

      // Illegal pair sets the sticky flag; a clear pulse drops it.
      cycle(1, 1, 3, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 0);

      // Backpressure: 6 held while 8 waits upstream.
      cycle(1, 2, 2, 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 3, 0, 0, 0);
      cycle(1, 3, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);

      // Back-to-back illegal pairs.
      cycle(1, 5, 0, 1, 0);
      cycle(1, 4, 1, 1, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);

      // Reset while holding a result discards it.
      cycle(1, 3, 3, 0, 0);
      cycle(0, 0, 0, 0, 0);
      do_reset();
      cycle(0, 0, 0, 0, 0);

      // Counter saturation, then clear coinciding with an illegal accept.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 3, 1, 1, 0);
      cycle(1, 7, 0, 1, 1);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);

      // Randomized traffic, including clears and rare resets.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
         end
      end
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
